dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory responder on the core's data side: it answers the execute unit's single-cycle memory requests (address, enable, read, write strobes) with an asynchronous-read byte RAM plus a small memory-mapped I/O page. The I/O page contains an 8-entry console transmit FIFO with a valid/ready drain port and a 16-bit free-running timer with a coherent two-byte read. It sits between the execute unit and the testbench or board-level console.

## Interface
- `RAM_DEPTH`, default 4080: number of RAM bytes, mapped at 0x000–0xFEF. Must be ≤ 4080.
- `CON_DEPTH`, default 8: console FIFO entries. Must be a power of 2, ≥ 2.
- `clk`  in  1: core clock.
- `reset_`  in  1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `d_mem_addr`  in  12: byte address from execute.
- `d_mem_en`  in  1: request valid.
- `d_mem_rd`  in  1: read request. Qualified by `d_mem_en`.
- `d_mem_wr`  in  1: write request. Qualified by `d_mem_en`.
- `d_mem_data_in`  in  8: write data (execute's outbound data).
- `d_mem_data_out`  out  8: read data (execute's inbound data).
- `con_data`  out  8: head byte of the console FIFO.
- `con_valid`  out  1: FIFO not empty.
- `con_ready`  in  1: downstream accepts `con_data` this cycle.

## Operation
- **Address map**
  - 0x000–0xFEF: RAM. Addresses at or above `RAM_DEPTH` read 0x00 and ignore writes.
  - 0xFF0 CON_DATA: a write pushes one byte; a read returns 0x00.
  - 0xFF1 CON_STAT: a read returns {5'b0, ovf, full, empty}. Any write clears `ovf`.
  - 0xFF2 TMR_LO: a read returns `timer[7:0]` and latches `timer[15:8]` into `tmr_snap`. Any write clears `timer` to 0.
  - 0xFF3 TMR_HI: a read returns `tmr_snap`. Writes are ignored.
  - 0xFF4 TMR_CTRL: bit0 = enable (R/W). Bits 7:1 read 0.
  - 0xFF5–0xFFF: read 0x00; writes are ignored.
- **Request decode**
  - A write is `d_mem_en & d_mem_wr`. A read is `d_mem_en & d_mem_rd & ~d_mem_wr`; when both strobes are high, the write wins.
  - `d_mem_data_out` is 0x00 whenever there is no read.
- **Console FIFO**
  - A push is a write to CON_DATA.
  - A pop happens when `con_valid & con_ready`.
  - A push when full with no same-cycle pop is dropped and sets sticky `ovf`.
  - A push when full with a same-cycle pop is accepted; occupancy is unchanged.
  - A push to an empty FIFO is not bypassed: `con_valid` rises on the next cycle.
  - `con_data` is meaningful only while `con_valid` is high.
- **Timer**
  - When enable = 1, `timer` increments every cycle and wraps from 0xFFFF to 0x0000.
  - A TMR_LO write in the same cycle as an increment leaves `timer` = 0 (the write wins).
- **Reset values**
  - `timer` = 0, `tmr_snap` = 0, enable = 0, `ovf` = 0, FIFO empty.
  - `con_valid` = 0, `con_data` = 0x00, `d_mem_data_out` = 0x00.
  - RAM contents are not reset.
- **Reset mid-operation**
  - The FIFO contents are discarded and `con_valid` drops on the cycle after the reset edge.
  - A write coinciding with asserted reset is ignored for I/O registers. It still updates the RAM.

## Timing
- Reads are combinational. `d_mem_data_out` is valid in the same cycle as the read strobes, because execute samples it combinationally.
- Writes commit on the rising edge of `clk`. Read-after-write to the same address returns the new data on the next cycle.
- A same-cycle read and write to the same address cannot occur, because the write wins.
- A TMR_LO read returns the value before that edge's increment. `tmr_snap` updates on the same edge.
- CON_STAT reflects registered state: a push in cycle N shows `empty` = 0 from cycle N+1.
- FIFO throughput is one push and one pop per cycle, sustained.

## Structure
- **Shared package `dmem_pkg`**
  - Address constants `ADDR_CON_DATA`, `ADDR_CON_STAT`, `ADDR_TMR_LO`, `ADDR_TMR_HI`, `ADDR_TMR_CTRL`, `IO_BASE` (0xFF0).
  - CON_STAT bit indices.
- **Sub-module `dmem_con_fifo`**
  - Synchronous FIFO parameterised by depth.
  - Ports: push/data in, pop, head data out, full, empty.
  - Occupancy counter is one bit wider than the pointers.
- **Top level**
  - RAM array, address decode, read mux, timer, and snapshot registers.

## Test plan
- **RAM round trip:** write 0xA5 to 0x123, then read 0x123 on the next cycle → `d_mem_data_out` = 0xA5. A read of 0xFF7 → 0x00.
- **Strobe conflict:** `d_mem_rd` and `d_mem_wr` both high to 0x010 with data 0x3C → RAM[0x010] = 0x3C and `d_mem_data_out` = 0x00 that cycle.
- **FIFO overflow:**
  - With `con_ready` = 0, push 0x01..0x09 → CON_STAT = 0x06 (full, ovf).
  - Then hold `con_ready` = 1 → bytes 0x01..0x08 drain in order, 0x09 is lost, and CON_STAT = 0x05.
  - Writing 0xFF1 → CON_STAT = 0x01.
- **Full with simultaneous push and pop:** FIFO full, `con_ready` = 1, push 0x77 → the FIFO stays full and 0x77 emerges eighth after the current head.
- **Timer coherence:**
  - Enable the timer, clear it, and wait until it reads 0x00FF.
  - Read TMR_LO (0xFF) and the next cycle read TMR_HI → 0x00, not 0x01.
  - 0xFFFF then wraps to 0x0000.
- **Mid-stream reset:** three bytes queued and `con_valid` = 1, assert `reset_` = 0 for one cycle → `con_valid` = 0, CON_STAT = 0x01, timer = 0, enable = 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared address map and status-bit layout for the data-memory responder.
package dmem_pkg;

  localparam logic [11:0] IO_BASE       = 12'hFF0;
  localparam logic [11:0] ADDR_CON_DATA = 12'hFF0;
  localparam logic [11:0] ADDR_CON_STAT = 12'hFF1;
  localparam logic [11:0] ADDR_TMR_LO   = 12'hFF2;
  localparam logic [11:0] ADDR_TMR_HI   = 12'hFF3;
  localparam logic [11:0] ADDR_TMR_CTRL = 12'hFF4;

  localparam int MAX_RAM_DEPTH = 4080;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

endpackage

// File: rtl/dmem_con_fifo.sv
// Console transmit FIFO: one push and one pop per cycle, head byte forced to 0 while empty.
module dmem_con_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign head  = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-side memory responder: async-read byte RAM plus an I/O page with console FIFO and timer.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int RAM_DEPTH = 4080,
  parameter int CON_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [11:0] d_mem_addr,
  input  logic        d_mem_en,
  input  logic        d_mem_rd,
  input  logic        d_mem_wr,
  input  logic [7:0]  d_mem_data_in,
  output logic [7:0]  d_mem_data_out,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready
);

  localparam int AW = $clog2(RAM_DEPTH);

  logic [7:0]  ram [RAM_DEPTH];
  logic        is_wr;
  logic        is_rd;
  logic        in_ram;
  logic [AW-1:0] ram_idx;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        ovf;
  logic [15:0] timer;
  logic [7:0]  tmr_snap;
  logic        tmr_en;
  logic [7:0]  stat;
  logic [7:0]  rd_data;

  // Write strobe dominates, so a read never sees a same-cycle write.
  assign is_wr   = d_mem_en & d_mem_wr;
  assign is_rd   = d_mem_en & d_mem_rd & ~d_mem_wr;
  assign in_ram  = int'(d_mem_addr) < RAM_DEPTH;
  assign ram_idx = d_mem_addr[AW-1:0];

  assign push = is_wr & reset_ & (d_mem_addr == ADDR_CON_DATA);
  assign pop  = con_valid & con_ready;

  dmem_con_fifo #(.DEPTH(CON_DEPTH)) u_con_fifo (
    .clk       (clk),
    .reset_    (reset_),
    .push      (push),
    .push_data (d_mem_data_in),
    .pop       (pop),
    .head      (con_data),
    .full      (full),
    .empty     (empty)
  );

  assign con_valid = ~empty;

  // RAM has no reset and keeps accepting writes while the I/O page is held in reset.
  always_ff @(posedge clk) begin
    if (is_wr && in_ram) ram[ram_idx] <= d_mem_data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      timer    <= '0;
      tmr_snap <= '0;
      tmr_en   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (push && full && !pop) begin
        ovf <= 1'b1;
      end else if (is_wr && d_mem_addr == ADDR_CON_STAT) begin
        ovf <= 1'b0;
      end
      if (is_wr && d_mem_addr == ADDR_TMR_LO) begin
        timer <= '0;
      end else if (tmr_en) begin
        timer <= timer + 16'd1;
      end
      if (is_rd && d_mem_addr == ADDR_TMR_LO) tmr_snap <= timer[15:8];
      if (is_wr && d_mem_addr == ADDR_TMR_CTRL) tmr_en <= d_mem_data_in[0];
    end
  end

  always_comb begin
    stat             = 8'h00;
    stat[STAT_EMPTY] = empty;
    stat[STAT_FULL]  = full;
    stat[STAT_OVF]   = ovf;
  end

  // Unmapped holes between RAM_DEPTH and the I/O page fall through to the default zero.
  always_comb begin
    rd_data = 8'h00;
    if (is_rd) begin
      if (in_ram) begin
        rd_data = ram[ram_idx];
      end else begin
        case (d_mem_addr)
          ADDR_CON_STAT: rd_data = stat;
          ADDR_TMR_LO:   rd_data = timer[7:0];
          ADDR_TMR_HI:   rd_data = tmr_snap;
          ADDR_TMR_CTRL: rd_data = {7'b0, tmr_en};
          default:       rd_data = 8'h00;
        endcase
      end
    end
  end

  assign d_mem_data_out = rd_data;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed and random bench for dmem_ctrl against a queue/array reference model.
module tb_dmem_ctrl;

  localparam int CON_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_;
  logic [11:0] d_mem_addr;
  logic        d_mem_en;
  logic        d_mem_rd;
  logic        d_mem_wr;
  logic [7:0]  d_mem_data_in;
  logic [7:0]  d_mem_data_out;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk            (clk),
    .reset_         (reset_),
    .d_mem_addr     (d_mem_addr),
    .d_mem_en       (d_mem_en),
    .d_mem_rd       (d_mem_rd),
    .d_mem_wr       (d_mem_wr),
    .d_mem_data_in  (d_mem_data_in),
    .d_mem_data_out (d_mem_data_out),
    .con_data       (con_data),
    .con_valid      (con_valid),
    .con_ready      (con_ready)
  );

  logic [7:0]  m_ram [4096];
  bit          m_known [4096];
  logic [7:0]  m_q [$];
  bit          m_ovf;
  int unsigned m_timer;
  logic [7:0]  m_snap;
  bit          m_en;
  bit          m_valid;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    assert (actual === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, checks combinational outputs, then advances the model past the edge.
  task automatic applyStimulus(input bit rst, input bit en, input bit rd, input bit wr,
                               input logic [11:0] a, input logic [7:0] d, input bit rdy,
                               output logic [7:0] rdval);
    bit         w;
    bit         r;
    bit         popn;
    int         old;
    logic [7:0] exp_rd;
    bit         exp_known;
    reset_        = ~rst;
    d_mem_en      = en;
    d_mem_rd      = rd;
    d_mem_wr      = wr;
    d_mem_addr    = a;
    d_mem_data_in = d;
    con_ready     = rdy;
    #2;
    rdval = d_mem_data_out;
    w = en & wr;
    r = en & rd & ~wr;
    exp_rd    = 8'h00;
    exp_known = 1'b1;
    if (r) begin
      if (a < 12'hFF0) begin
        exp_rd    = m_ram[a];
        exp_known = m_known[a];
      end else if (a == 12'hFF1) begin
        exp_rd = {5'b0, m_ovf, m_q.size() == CON_DEPTH, m_q.size() == 0};
      end else if (a == 12'hFF2) begin
        exp_rd = 8'(m_timer & 32'hFF);
      end else if (a == 12'hFF3) begin
        exp_rd = m_snap;
      end else if (a == 12'hFF4) begin
        exp_rd = {7'b0, m_en};
      end
    end
    if (m_valid) begin
      if (exp_known) checkOutput("data_out", d_mem_data_out, exp_rd);
      checkOutput("con_valid", {7'b0, con_valid}, {7'b0, m_q.size() != 0});
      checkOutput("con_data", con_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
    end
    if (w && a < 12'hFF0) begin
      m_ram[a]   = d;
      m_known[a] = 1'b1;
    end
    if (rst) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_timer = 0;
      m_snap  = 8'h00;
      m_en    = 1'b0;
      m_valid = 1'b1;
    end else begin
      old  = m_q.size();
      popn = (old != 0) && rdy;
      if (popn) void'(m_q.pop_front());
      if (w && a == 12'hFF0) begin
        if (old < CON_DEPTH || popn) m_q.push_back(d);
        else m_ovf = 1'b1;
      end
      if (w && a == 12'hFF1) m_ovf = 1'b0;
      if (r && a == 12'hFF2) m_snap = 8'((m_timer >> 8) & 32'hFF);
      if (w && a == 12'hFF2) m_timer = 0;
      else if (m_en) m_timer = (m_timer + 1) % 65536;
      if (w && a == 12'hFF4) m_en = d[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wrByte(input logic [11:0] a, input logic [7:0] d, input bit rdy);
    logic [7:0] unused;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, a, d, rdy, unused);
  endtask

  task automatic rdByte(input logic [11:0] a, output logic [7:0] v);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a, 8'h00, 1'b0, v);
  endtask

  task automatic idle(input bit rdy);
    logic [7:0] unused;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, rdy, unused);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] exp_drain [8];
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_timer = 0;
    m_snap  = 8'h00;
    m_en    = 1'b0;
    for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 8'h00, 1'b0, v);
    checkOutput("rst_con_valid", {7'b0, con_valid}, 8'h00);
    checkOutput("rst_con_data", con_data, 8'h00);
    rdByte(12'hFF1, v); checkOutput("rst_stat", v, 8'h01);
    rdByte(12'hFF2, v); checkOutput("rst_tmr_lo", v, 8'h00);
    rdByte(12'hFF3, v); checkOutput("rst_tmr_hi", v, 8'h00);
    rdByte(12'hFF4, v); checkOutput("rst_tmr_ctrl", v, 8'h00);

    wrByte(12'h123, 8'hA5, 1'b0);
    rdByte(12'h123, v); checkOutput("ram_rt", v, 8'hA5);
    rdByte(12'hFF7, v); checkOutput("unmapped", v, 8'h00);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'h010, 8'h3C, 1'b0, v);
    checkOutput("conflict_out", v, 8'h00);
    rdByte(12'h010, v); checkOutput("conflict_ram", v, 8'h3C);

    for (int i = 1; i <= 9; i++) wrByte(12'hFF0, 8'(i), 1'b0);
    rdByte(12'hFF1, v); checkOutput("ovf_stat", v, 8'h06);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("drain_valid", {7'b0, con_valid}, 8'h01);
      checkOutput("drain_data", con_data, 8'(i));
      idle(1'b1);
    end
    checkOutput("drain_empty", {7'b0, con_valid}, 8'h00);
    rdByte(12'hFF1, v); checkOutput("ovf_sticky", v, 8'h05);
    wrByte(12'hFF1, 8'h00, 1'b0);
    rdByte(12'hFF1, v); checkOutput("ovf_clear", v, 8'h01);

    for (int i = 0; i < 8; i++) wrByte(12'hFF0, 8'(8'h10 + i), 1'b0);
    rdByte(12'hFF1, v); checkOutput("full_stat", v, 8'h02);
    checkOutput("full_head", con_data, 8'h10);
    wrByte(12'hFF0, 8'h77, 1'b1);
    rdByte(12'hFF1, v); checkOutput("pushpop_stat", v, 8'h02);
    for (int i = 0; i < 7; i++) exp_drain[i] = 8'(8'h11 + i);
    exp_drain[7] = 8'h77;
    for (int i = 0; i < 8; i++) begin
      checkOutput("pushpop_order", con_data, exp_drain[i]);
      idle(1'b1);
    end
    checkOutput("pushpop_empty", {7'b0, con_valid}, 8'h00);

    wrByte(12'hFF4, 8'h01, 1'b0);
    wrByte(12'hFF2, 8'h00, 1'b0);
    for (int n = 0; n < 70000 && m_timer != 32'h00FF; n++) idle(1'b0);
    rdByte(12'hFF2, v); checkOutput("tmr_lo_ff", v, 8'hFF);
    rdByte(12'hFF3, v); checkOutput("tmr_hi_snap", v, 8'h00);
    for (int n = 0; n < 70000 && m_timer != 32'hFFFF; n++) idle(1'b0);
    rdByte(12'hFF2, v); checkOutput("tmr_lo_top", v, 8'hFF);
    rdByte(12'hFF2, v); checkOutput("tmr_wrap_lo", v, 8'h00);
    rdByte(12'hFF3, v); checkOutput("tmr_wrap_hi", v, 8'h00);

    for (int i = 0; i < 3; i++) wrByte(12'hFF0, 8'(8'hC0 + i), 1'b0);
    checkOutput("pre_rst_valid", {7'b0, con_valid}, 8'h01);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 12'h200, 8'h5A, 1'b0, v);
    checkOutput("mid_rst_valid", {7'b0, con_valid}, 8'h00);
    rdByte(12'hFF1, v); checkOutput("mid_rst_stat", v, 8'h01);
    rdByte(12'hFF2, v); checkOutput("mid_rst_timer", v, 8'h00);
    rdByte(12'hFF4, v); checkOutput("mid_rst_en", v, 8'h00);
    rdByte(12'h200, v); checkOutput("rst_ram_write", v, 8'h5A);

    for (int n = 0; n < 800; n++) begin
      int         sel;
      logic [11:0] a;
      sel = $urandom_range(0, 3);
      if (sel == 0)      a = 12'hFF0 + 12'($urandom_range(0, 15));
      else if (sel == 1) a = 12'hFF0;
      else               a = 12'($urandom_range(0, 63));
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    a, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 2) == 0), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
